// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: fetch-side instruction RAM with fixed-latency valid/ready response.
// Define INST_FETCH_B2B_EN to allow a new accept in the response handshake cycle.
module inst_fetch_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    localparam int         IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic          rsp_err,
    input  logic          flush,
    input  logic          ld_en,
    input  logic [IW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 2;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [63:0]   offset;
    logic [IW-1:0] rd_idx;
    logic          addr_err;
    logic          accept;

    // offset wraps for addresses below BASE_ADDR, so both bounds are tested
    assign offset   = req_addr - BASE_ADDR;
    assign rd_idx   = offset[IW+1:2];
    assign addr_err = (req_addr[1:0] != 2'b00)
                    | (req_addr < BASE_ADDR)
                    | (offset >= SPAN);

`ifdef INST_FETCH_B2B_EN
    assign req_ready = ((state == IDLE) | ((state == RESP) & rsp_ready))
                     & ~flush & ~rst;
`else
    assign req_ready = (state == IDLE) & ~flush & ~rst;
`endif

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_inst  <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // an accept overrides the handshake return to IDLE
            if (accept) begin
                rsp_inst <= addr_err ? 32'h0 : mem[rd_idx];
                rsp_err  <= addr_err;
                cnt      <= CNT_INIT;
                if (LATENCY == 1) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end else begin
                    state     <= WAIT;
                    rsp_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: two responders (LATENCY 1 and 3) checked by a
// queue scoreboard fed from an address/memory reference model.
`timescale 1ns/1ps
module tb_inst_fetch_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
`ifdef INST_FETCH_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [63:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_inst  [2];
    logic        rsp_err   [2];
    logic        flush     [2];
    logic        ld_en     [2];
    logic [11:0] ld_idx    [2];
    logic [31:0] ld_data   [2];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;
    int rmode [2];
    logic [31:0] mm [2][DEPTH];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]), .flush(flush[0]),
        .ld_en(ld_en[0]), .ld_idx(ld_idx[0]), .ld_data(ld_data[0])
    );

    inst_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]), .flush(flush[1]),
        .ld_en(ld_en[1]), .ld_idx(ld_idx[1]), .ld_data(ld_data[1])
    );

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpush(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic void qpop(int d);
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    function automatic void qclear(int d);
        if (d == 0) q0.delete();
        else q1.delete();
    endfunction

    // expected response straight from the address map and model memory
    function automatic exp_t model(int d, logic [63:0] a);
        exp_t e;
        e.acc = 0;
        if (a[1:0] != 2'b00 || a < BASE || (a - BASE) >= 64'(DEPTH) * 4) begin
            e.err  = 1'b1;
            e.inst = 32'h0;
        end else begin
            e.err  = 1'b0;
            e.inst = mm[d][int'((a - BASE) >> 2)];
        end
        return e;
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h want %h at cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    // monitor: response timing, ready and data against the scoreboard
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                exp_t f;
                bit ev;
                bit er;
                ev = 1'b0;
                if (qsize(d) != 0) begin
                    f  = qfront(d);
                    ev = (cyc - f.acc) >= lat(d) - 1;
                end
                er = (qsize(d) == 0 || (B2B && ev && rsp_ready[d] === 1'b1))
                   && !flush[d] && !rst[d];
                chk("rsp_valid", d, 64'(rsp_valid[d]), 64'(ev));
                chk("req_ready", d, 64'(req_ready[d]), 64'(er));
                if (ev) begin
                    chk("rsp_inst", d, 64'(rsp_inst[d]), 64'(f.inst));
                    chk("rsp_err", d, 64'(rsp_err[d]), 64'(f.err));
                    if (rsp_ready[d] && !flush[d] && !rst[d]) qpop(d);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rmode[d] == 0) rsp_ready[d] = 1'b1;
            else if (rmode[d] == 1) rsp_ready[d] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(int d, logic [63:0] a, bit dold, logic [11:0] li,
                         logic [31:0] ldat, output int acc);
        exp_t e;
        bit ok;
        ok  = 1'b0;
        acc = -1;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        if (dold) begin
            ld_en[d]   = 1'b1;
            ld_idx[d]  = li;
            ld_data[d] = ldat;
        end
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                e  = model(d, a);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (dold && t == 0) begin
                mm[d][li] = ldat;
                ld_en[d]  = 1'b0;
            end
        end
        req_valid[d] = 1'b0;
        if (ok) begin
            e.acc = cyc;
            acc   = cyc;
            qpush(d, e);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout dut%0d addr %h: got no req_ready, want ready within 100 cycles", d, a);
        end
    endtask

    task automatic do_flush(int d);
        flush[d] = 1'b1;
        step(1);
        flush[d] = 1'b0;
        qclear(d);
    endtask

    task automatic do_reset(int d);
        rst[d] = 1'b1;
        step(1);
        qclear(d);
        @(negedge clk);
        chk("reset_rsp_valid", d, 64'(rsp_valid[d]), 64'(0));
        chk("reset_rsp_inst", d, 64'(rsp_inst[d]), 64'(0));
        chk("reset_rsp_err", d, 64'(rsp_err[d]), 64'(0));
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    task automatic drain(int d);
        int t = 0;
        while (qsize(d) != 0 && t < 200) begin
            step(1);
            t++;
        end
        n_chk++;
        if (qsize(d) != 0) begin
            n_fail++;
            $display("FAIL drain dut%0d: got %0d responses pending, want 0", d, qsize(d));
        end
    endtask

    task automatic load_both(logic [11:0] idx, logic [31:0] data);
        for (int d = 0; d < 2; d++) begin
            ld_en[d]   = 1'b1;
            ld_idx[d]  = idx;
            ld_data[d] = data;
        end
        step(1);
        for (int d = 0; d < 2; d++) begin
            mm[d][idx] = data;
            ld_en[d]   = 1'b0;
        end
    endtask

    initial begin
        int acc;
        int r;
        int accs [4];
        logic [63:0] pa;
        logic [31:0] w;
        logic [63:0] eaddr [6];

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            req_valid[d] = 1'b0;
            req_addr[d] = 64'h0;
            rsp_ready[d] = 1'b1;
            flush[d] = 1'b0;
            ld_en[d] = 1'b0;
            ld_idx[d] = 12'h0;
            ld_data[d] = 32'h0;
            rmode[d] = 0;
        end
        step(1);
        do_reset(0);
        do_reset(1);
        started = 1'b1;

        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (i == 0) w = 32'h0000_0413;
            if (i == 1) w = 32'h0084_0493;
            load_both(12'(i), w);
        end
        load_both(12'hFFF, 32'h0000_0073);

        // sequential fetches at LATENCY 1
        issue(0, BASE, 1'b0, 12'h0, 32'h0, acc);
        issue(0, BASE + 64'h4, 1'b0, 12'h0, 32'h0, acc);
        drain(0);

        // LATENCY 3 response held while the fetch stage stalls
        rmode[1] = 2;
        rsp_ready[1] = 1'b0;
        issue(1, BASE + 64'h4, 1'b0, 12'h0, 32'h0, acc);
        step(6);
        rsp_ready[1] = 1'b1;
        step(1);
        rmode[1] = 0;
        drain(1);

        // error decode and the last in-range word
        eaddr[0] = BASE + 64'h2;
        eaddr[1] = BASE - 64'h4;
        eaddr[2] = BASE + 64'h4000;
        eaddr[3] = BASE + 64'h3FFC;
        eaddr[4] = 64'hFFFF_FFFF_FFFF_FFFC;
        eaddr[5] = BASE + 64'h1;
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 2; d++) begin
                issue(d, eaddr[i], 1'b0, 12'h0, 32'h0, acc);
                drain(d);
            end
        end

        // flush in WAIT, then a clean fetch
        issue(1, BASE, 1'b0, 12'h0, 32'h0, acc);
        do_flush(1);
        step(3);
        issue(1, BASE + 64'h4, 1'b0, 12'h0, 32'h0, acc);
        drain(1);

        // flush in RESP with rsp_ready high drops the response
        issue(0, BASE + 64'h8, 1'b0, 12'h0, 32'h0, acc);
        do_flush(0);
        step(2);

        // flush in IDLE blocks acceptance
        flush[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0] = BASE;
        step(1);
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        step(3);

        // load in the accept cycle returns old data, next fetch sees new
        issue(0, BASE, 1'b1, 12'h0, 32'hDEAD_BEEF, acc);
        drain(0);
        issue(0, BASE, 1'b0, 12'h0, 32'h0, acc);
        drain(0);

        // reset while holding a response
        rmode[0] = 2;
        rsp_ready[0] = 1'b0;
        issue(0, BASE + 64'h4, 1'b0, 12'h0, 32'h0, acc);
        step(1);
        do_reset(0);
        rmode[0] = 0;
        step(2);

        // continuous requests: one per cycle with B2B, else one per two
        for (int i = 0; i < 4; i++) begin
            issue(0, BASE + 64'(4 * i), 1'b0, 12'h0, 32'h0, acc);
            accs[i] = acc;
        end
        for (int i = 1; i < 4; i++) begin
            chk("accept_gap", 0, 64'(accs[i] - accs[i-1]), B2B ? 64'(1) : 64'(2));
        end
        drain(0);

        // randomized traffic with loads, stalls and flushes
        for (int d = 0; d < 2; d++) begin
            rmode[d] = 1;
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 9);
                if (r < 6) pa = BASE + 64'(4 * $urandom_range(0, 63));
                else if (r == 6) pa = BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
                else if (r == 7) pa = BASE - 64'(4 * $urandom_range(1, 8));
                else if (r == 8) pa = BASE + 64'h4000 + 64'(4 * $urandom_range(0, 8));
                else pa = BASE + 64'h3FFC;
                issue(d, pa, $urandom_range(0, 3) == 0, 12'($urandom_range(0, 63)),
                      $urandom, acc);
                if ($urandom_range(0, 6) == 0) do_flush(d);
                step($urandom_range(0, 2));
            end
            rmode[d] = 0;
            drain(d);
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
